// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the data-RAM arbiter: response owner, grant id, full byte mask.
// Pure declarations: no latency, no backpressure.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_IF    = 2'd1,
      OWN_LS_RD = 2'd2,
      OWN_LS_WR = 2'd3
   } resp_owner_t;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_LS = 1'b1;

   localparam logic [3:0] BE_FULL = 4'hF;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker; grant is combinational from req and the last winner.
// No backpressure: a lone request always wins, a tie goes to whoever did not win last.
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_grant;

   always_comb begin
      gnt = 2'b00;
      if (req[GNT_IF] && (!req[GNT_LS] || last_grant == GNT_LS)) begin
         gnt[GNT_IF] = 1'b1;
      end else if (req[GNT_LS]) begin
         gnt[GNT_LS] = 1'b1;
      end
   end

   // Reset to LS so instruction fetch wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_grant <= GNT_LS;
      end else if (|gnt) begin
         last_grant <= gnt[GNT_LS];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port RAM between fetch and load/store; same-cycle grant, response 1 cycle later.
// Losing requester holds its request until granted; ties alternate so nobody waits more than one cycle.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [3:0]        ls_be,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ram_en,
   output logic              ram_wren,
   output logic [3:0]        ram_be,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [CNT_W-1:0]  contention_cnt
);

   logic [1:0]  gnt;
   resp_owner_t resp_owner;
   resp_owner_t resp_owner_nxt;

   rr_arb2 u_rr_arb2 (
      .clk (clk),
      .rst (rst),
      .req ({ls_req, if_req}),
      .gnt (gnt)
   );

   assign if_gnt = gnt[GNT_IF];
   assign ls_gnt = gnt[GNT_LS];

   always_comb begin
      ram_en         = 1'b0;
      ram_wren       = 1'b0;
      ram_be         = 4'h0;
      ram_addr       = '0;
      ram_wdata      = '0;
      resp_owner_nxt = OWN_NONE;
      if (if_gnt) begin
         ram_en         = 1'b1;
         ram_be         = BE_FULL;
         ram_addr       = if_addr;
         resp_owner_nxt = OWN_IF;
      end else if (ls_gnt) begin
         ram_en         = 1'b1;
         ram_wren       = ls_we;
         ram_be         = ls_we ? ls_be : BE_FULL;
         ram_addr       = ls_addr;
         ram_wdata      = ls_wdata;
         resp_owner_nxt = ls_we ? OWN_LS_WR : OWN_LS_RD;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         resp_owner <= OWN_NONE;
      end else begin
         resp_owner <= resp_owner_nxt;
      end
   end

   // Flush only hides the fetch response; the RAM read already happened.
   assign if_rvalid = (resp_owner == OWN_IF) && !if_flush;
   assign if_rdata  = if_rvalid ? ram_rdata : '0;
   assign ls_rvalid = (resp_owner == OWN_LS_RD) || (resp_owner == OWN_LS_WR);
   assign ls_rdata  = (resp_owner == OWN_LS_RD) ? ram_rdata : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         contention_cnt <= '0;
      end else if (if_req && ls_req && (contention_cnt != {CNT_W{1'b1}})) begin
         contention_cnt <= contention_cnt + 1'b1;
      end
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port data RAM (1-cycle registered read) between two requesters: instruction fetch (IF) and load/store unit (LS).
- Performs round-robin arbitration with same-cycle grant and returns a response one cycle after grant.
- Maintains a saturating contention counter for performance monitoring.
- Sits between the CPU core and the ram instance.

Parameters:
ADDR_W, 7, word-address width (RAM depth 2^ADDR_W words)
DATA_W, 32, data word width
CNT_W, 16, contention counter width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low
if_req  input  1  fetch read request; addr held stable until granted
if_addr  input  ADDR_W  fetch word address
if_flush  input  1  discard any fetch response due this cycle (branch taken)
if_gnt  output  1  fetch request accepted this cycle
if_rvalid  output  1  fetch read data valid
if_rdata  output  DATA_W  fetch read data
ls_req  input  1  load/store request; fields held stable until granted
ls_we  input  1  1 = store, 0 = load
ls_addr  input  ADDR_W  LS word address
ls_be  input  4  store byte enables
ls_wdata  input  DATA_W  store data
ls_gnt  output  1  LS request accepted this cycle
ls_rvalid  output  1  LS response valid (load data or store ack)
ls_rdata  output  DATA_W  load data; 0 on store ack
ram_en  output  1  RAM access this cycle
ram_wren  output  1  RAM write
ram_be  output  4  RAM byte enables
ram_addr  output  ADDR_W  RAM address
ram_wdata  output  DATA_W  RAM write data
ram_rdata  input  DATA_W  RAM read data, valid the cycle after ram_en
contention_cnt  output  CNT_W  cycles in which both requesters asked

Behaviour:
- Reset: clk and rst are the single clock and reset. rst is asynchronous and active-low. While rst is low: if_rvalid=0, ls_rvalid=0, resp_owner=NONE, last_grant=LS (IF wins the first tie), contention_cnt=0. Any outstanding response is dropped; no rvalid follows reset release.
- Grant logic is combinational from the requests and last_grant:
  - Only one requester: it is granted.
  - Both requesting: grant goes to the requester not in last_grant.
  - Neither: no grant, ram_en=0, ram_wren=0, ram_be=0.
- Exactly one of if_gnt and ls_gnt is high whenever any request is high. Handshake = req and gnt both high in the same cycle.
- RAM drive (combinational from the granted request):
  - IF granted: ram_en=1, ram_wren=0, ram_be=4'hF, ram_addr=if_addr, ram_wdata=0.
  - LS granted: ram_en=1, ram_wren=ls_we, ram_be = ls_we ? ls_be : 4'hF, ram_addr=ls_addr, ram_wdata=ls_wdata.
- Sequential state:
  - last_grant updates only on a grant.
  - resp_owner (NONE/IF/LS_RD/LS_WR) registers the grant type each cycle; NONE if no grant.
- Response, cycle N+1 after a grant in cycle N:
  - IF: if_rvalid = (resp_owner==IF) and not if_flush; if_rdata=ram_rdata.
  - LS load: ls_rvalid=1, ls_rdata=ram_rdata.
  - LS store: ls_rvalid=1, ls_rdata=0. The write is committed by the RAM at the end of cycle N.
  - rdata outputs are 0 when the matching rvalid is low.
- Latency: 1 cycle, grant to response. Throughput: one access per cycle. Back-to-back grants are allowed; a new grant in N+1 coexists with the response for N.
- Response state machine:
  - NONE→IF/LS_RD/LS_WR on the corresponding grant; any state→NONE with no grant.
  - if_flush only masks if_rvalid; it never cancels a same-cycle grant.
- Contention counter: increments when if_req and ls_req are both high; saturates at 2^CNT_W-1 (no wrap).
- Simultaneous requests in consecutive cycles alternate grants strictly, so neither requester waits more than one cycle.
- A request dropped before grant is legal; nothing is issued for it.

Decomposition:
- Shared package: response-owner encoding (NONE=0, IF=1, LS_RD=2, LS_WR=3), grant ID encoding (IF=0, LS=1), full byte-enable constant 4'hF.
- Optional sub-module rr_arb2: a two-input round-robin picker holding the last_grant register (req[1:0] in, gnt[1:0] out). Everything else stays in mem_arbiter.

Test Plan:
- Reset pulse mid-access: ls load granted, rst low the next cycle → ls_rvalid stays 0; after release, the first tie grants IF.
- IF only, if_addr=5, RAM word5=32'hDEADBEEF → if_gnt same cycle; if_rvalid=1 and if_rdata=32'hDEADBEEF one cycle later.
- Both requesting for 4 cycles from reset → grants IF, LS, IF, LS; contention_cnt=4; responses land on the matching port each next cycle.
- LS store addr=3, be=4'b0011, wdata=32'h0000ABCD → ram_wren=1, ram_be=4'b0011, ls_rvalid=1 with ls_rdata=0 next cycle; a following load of addr 3 returns the updated low half.
- IF granted, if_flush=1 in the response cycle → if_rvalid=0, and a new IF grant that same cycle responds normally.
- CNT_W=2, both requesting 6 cycles → contention_cnt saturates at 3.
